// File: rtl/ocp_arb2_if.sv
// OCP request/response channel bundle plus shared widths and encodings.
// Latency: none, wires only.
// Backpressure: SCmdAccept carries the slave-side accept back to the requester.
package ocp_arb2_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int BEN_WIDTH  = 4;

    localparam logic [2:0] OCP_CMD_IDLE  = 3'd0;
    localparam logic [2:0] OCP_CMD_WRITE = 3'd1;
    localparam logic [2:0] OCP_CMD_READ  = 3'd2;

    localparam logic [1:0] OCP_RESP_NULL = 2'd0;
    localparam logic [1:0] OCP_RESP_DVA  = 2'd1;
    localparam logic [1:0] OCP_RESP_ERR  = 2'd3;
endpackage

interface ocp_arb2_if;
    import ocp_arb2_pkg::*;

    logic [ADDR_WIDTH-1:0] MAddr;
    logic [2:0]            MCmd;
    logic [DATA_WIDTH-1:0] MData;
    logic [BEN_WIDTH-1:0]  MByteEn;
    logic                  SCmdAccept;
    logic [DATA_WIDTH-1:0] SData;
    logic [1:0]            SResp;

    // Requester side of the channel.
    modport master (
        output MAddr, MCmd, MData, MByteEn,
        input  SCmdAccept, SData, SResp
    );

    // Responder side of the channel.
    modport slave (
        input  MAddr, MCmd, MData, MByteEn,
        output SCmdAccept, SData, SResp
    );
endinterface

// File: rtl/ocp_arb2.sv
// Two-master OCP arbiter (M0 fetch, M1 data) onto one slave, one transaction in flight.
// Latency: zero-cycle combinational request and response paths; at least one IDLE cycle between transactions.
// Backpressure: slave stalls lock the grant to the stalled master; the loser sees SCmdAccept=0 until served.
module ocp_arb2
    import ocp_arb2_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       nrst,
    ocp_arb2_if.slave  m0_i,
    ocp_arb2_if.slave  m1_i,
    ocp_arb2_if.master s_o
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEADDEAD;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_BUSY0 = 3'b010,
        ST_BUSY1 = 3'b100
    } state_t;

    state_t          state_q;
    logic            last_id_q;
    logic            lock_vld_q;
    logic            lock_id_q;
    logic [TW-1:0]   tmo_cnt_q;

    logic            req0;
    logic            req1;
    logic            sel;
    logic            fwd_vld;
    logic            resp_vld;
    logic            tmo_hit;

    // Request decode and grant selection: a stalled grant is sticky, otherwise round-robin on ties.
    always_comb begin
        req0 = (m0_i.MCmd != OCP_CMD_IDLE);
        req1 = (m1_i.MCmd != OCP_CMD_IDLE);
        sel  = ~last_id_q;
        if (lock_vld_q) begin
            sel = lock_id_q;
        end else if (req0 ^ req1) begin
            sel = req1;
        end
        // Reset gates forwarding so the slave sees IDLE while nrst is low.
        fwd_vld  = nrst && (state_q == ST_IDLE) && (sel ? req1 : req0);
        resp_vld = (s_o.SResp != OCP_RESP_NULL);
        // A real response in the final cycle beats the timeout.
        tmo_hit  = !resp_vld && (tmo_cnt_q == TMO_LAST);
    end

    // Slave-side request mux: only the selected master, only while IDLE.
    always_comb begin
        s_o.MCmd    = OCP_CMD_IDLE;
        s_o.MAddr   = '0;
        s_o.MData   = '0;
        s_o.MByteEn = '0;
        if (fwd_vld) begin
            if (sel) begin
                s_o.MCmd    = m1_i.MCmd;
                s_o.MAddr   = m1_i.MAddr;
                s_o.MData   = m1_i.MData;
                s_o.MByteEn = m1_i.MByteEn;
            end else begin
                s_o.MCmd    = m0_i.MCmd;
                s_o.MAddr   = m0_i.MAddr;
                s_o.MData   = m0_i.MData;
                s_o.MByteEn = m0_i.MByteEn;
            end
        end
    end

    // Master-side accept and response routing; the non-owner always sees NULL/0.
    always_comb begin
        m0_i.SCmdAccept = !req0 || (fwd_vld && !sel && s_o.SCmdAccept);
        m1_i.SCmdAccept = !req1 || (fwd_vld &&  sel && s_o.SCmdAccept);
        m0_i.SResp      = OCP_RESP_NULL;
        m0_i.SData      = '0;
        m1_i.SResp      = OCP_RESP_NULL;
        m1_i.SData      = '0;
        if (state_q == ST_BUSY0) begin
            m0_i.SResp = tmo_hit ? OCP_RESP_ERR : s_o.SResp;
            m0_i.SData = tmo_hit ? ERR_DATA     : s_o.SData;
        end
        if (state_q == ST_BUSY1) begin
            m1_i.SResp = tmo_hit ? OCP_RESP_ERR : s_o.SResp;
            m1_i.SData = tmo_hit ? ERR_DATA     : s_o.SData;
        end
    end

    // Arbitration FSM: grant/lock bookkeeping in IDLE, response or timeout exit from BUSY.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            last_id_q  <= 1'b1;
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fwd_vld) begin
                        if (s_o.SCmdAccept) begin
                            state_q    <= sel ? ST_BUSY1 : ST_BUSY0;
                            last_id_q  <= sel;
                            lock_vld_q <= 1'b0;
                            tmo_cnt_q  <= '0;
                        end else begin
                            lock_vld_q <= 1'b1;
                            lock_id_q  <= sel;
                        end
                    end else begin
                        // Locked master withdrew its command; release the lock.
                        lock_vld_q <= 1'b0;
                    end
                end
                ST_BUSY0, ST_BUSY1: begin
                    if (tmo_cnt_q != '1) begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                    if (resp_vld || tmo_hit) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ocp_arb2.sv
// Directed bench for ocp_arb2 with TIMEOUT=4.
// Latency: checks sampled on the falling edge, stimulus driven 1 time unit after the rising edge.
// Backpressure: slave accept and responses are driven directly by the bench.
module tb_ocp_arb2;
    import ocp_arb2_pkg::*;

    logic clk = 1'b0;
    logic nrst;
    int   ncmp = 0;
    int   nerr = 0;

    ocp_arb2_if m0 ();
    ocp_arb2_if m1 ();
    ocp_arb2_if s ();

    ocp_arb2 #(.TIMEOUT(4)) dut (
        .clk  (clk),
        .nrst (nrst),
        .m0_i (m0),
        .m1_i (m1),
        .s_o  (s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic gid;

        nrst         = 1'b0;
        m0.MCmd      = OCP_CMD_READ;
        m0.MAddr     = 32'h77;
        m0.MData     = '0;
        m0.MByteEn   = '0;
        m1.MCmd      = OCP_CMD_IDLE;
        m1.MAddr     = '0;
        m1.MData     = '0;
        m1.MByteEn   = '0;
        s.SCmdAccept = 1'b1;
        s.SResp      = OCP_RESP_NULL;
        s.SData      = '0;

        // Reset values with M0 requesting
        @(negedge clk);
        chk("rst_mcmd",  s.MCmd, OCP_CMD_IDLE);
        chk("rst_maddr", s.MAddr, 0);
        chk("rst_acc0",  m0.SCmdAccept, 0);
        chk("rst_acc1",  m1.SCmdAccept, 1);
        chk("rst_resp0", m0.SResp, OCP_RESP_NULL);
        m0.MCmd = OCP_CMD_IDLE;
        cyc();
        nrst = 1'b1;

        // Single M0 read
        m0.MCmd = OCP_CMD_READ; m0.MAddr = 32'h10; s.SCmdAccept = 1'b1;
        @(negedge clk);
        chk("rd_mcmd",  s.MCmd, OCP_CMD_READ);
        chk("rd_maddr", s.MAddr, 32'h10);
        chk("rd_acc0",  m0.SCmdAccept, 1);
        cyc();
        m0.MCmd = OCP_CMD_IDLE; s.SResp = OCP_RESP_DVA; s.SData = 32'h12345678;
        @(negedge clk);
        chk("rd_resp0", m0.SResp, OCP_RESP_DVA);
        chk("rd_data0", m0.SData, 32'h12345678);
        chk("rd_resp1", m1.SResp, OCP_RESP_NULL);
        chk("rd_data1", m1.SData, 0);
        chk("rd_busy_mcmd", s.MCmd, OCP_CMD_IDLE);
        cyc();
        s.SResp = OCP_RESP_NULL; s.SData = '0;

        // Tie round-robin from reset: M0, M1, M0, M1, two cycles each
        nrst = 1'b0;
        cyc();
        nrst = 1'b1;
        m0.MCmd = OCP_CMD_READ; m0.MAddr = 32'h100;
        m1.MCmd = OCP_CMD_READ; m1.MAddr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            gid = k[0];
            @(negedge clk);
            chk("rr_maddr", s.MAddr, gid ? 32'h200 : 32'h100);
            chk("rr_acc0",  m0.SCmdAccept, !gid);
            chk("rr_acc1",  m1.SCmdAccept, gid);
            cyc();
            s.SResp = OCP_RESP_DVA; s.SData = 32'(k);
            @(negedge clk);
            chk("rr_resp_win",  gid ? m1.SResp : m0.SResp, OCP_RESP_DVA);
            chk("rr_resp_lose", gid ? m0.SResp : m1.SResp, OCP_RESP_NULL);
            cyc();
            s.SResp = OCP_RESP_NULL; s.SData = '0;
        end
        m0.MCmd = OCP_CMD_IDLE; m1.MCmd = OCP_CMD_IDLE;

        // M1 write pass-through
        m1.MCmd = OCP_CMD_WRITE; m1.MAddr = 32'h20; m1.MData = 32'hAABBCCDD; m1.MByteEn = 4'b0101;
        @(negedge clk);
        chk("wr_mcmd",  s.MCmd, OCP_CMD_WRITE);
        chk("wr_maddr", s.MAddr, 32'h20);
        chk("wr_mdata", s.MData, 32'hAABBCCDD);
        chk("wr_ben",   s.MByteEn, 4'b0101);
        chk("wr_acc1",  m1.SCmdAccept, 1);
        cyc();
        m1.MCmd = OCP_CMD_IDLE; s.SResp = OCP_RESP_DVA;
        @(negedge clk);
        chk("wr_resp1", m1.SResp, OCP_RESP_DVA);
        cyc();
        s.SResp = OCP_RESP_NULL;

        // Stall lock on M1 while M0 joins
        s.SCmdAccept = 1'b0; m1.MCmd = OCP_CMD_READ; m1.MAddr = 32'h30;
        @(negedge clk);
        chk("st1_maddr", s.MAddr, 32'h30);
        chk("st1_acc1",  m1.SCmdAccept, 0);
        cyc();
        m0.MCmd = OCP_CMD_READ; m0.MAddr = 32'h40;
        @(negedge clk);
        chk("st2_maddr", s.MAddr, 32'h30);
        chk("st2_mcmd",  s.MCmd, OCP_CMD_READ);
        chk("st2_acc0",  m0.SCmdAccept, 0);
        cyc();
        @(negedge clk);
        chk("st3_maddr", s.MAddr, 32'h30);
        chk("st3_acc0",  m0.SCmdAccept, 0);
        cyc();
        s.SCmdAccept = 1'b1;
        @(negedge clk);
        chk("st4_maddr", s.MAddr, 32'h30);
        chk("st4_acc1",  m1.SCmdAccept, 1);
        chk("st4_acc0",  m0.SCmdAccept, 0);
        cyc();
        m1.MCmd = OCP_CMD_IDLE; s.SResp = OCP_RESP_DVA;
        @(negedge clk);
        chk("st5_resp1", m1.SResp, OCP_RESP_DVA);
        chk("st5_acc0",  m0.SCmdAccept, 0);
        chk("st5_mcmd",  s.MCmd, OCP_CMD_IDLE);
        cyc();
        s.SResp = OCP_RESP_NULL;
        @(negedge clk);
        chk("st6_maddr", s.MAddr, 32'h40);
        chk("st6_acc0",  m0.SCmdAccept, 1);
        cyc();
        m0.MCmd = OCP_CMD_IDLE; s.SResp = OCP_RESP_DVA;
        cyc();
        s.SResp = OCP_RESP_NULL;

        // Timeout: silent slave, ERR on 4th BUSY cycle, late DVA ignored
        m0.MCmd = OCP_CMD_READ; m0.MAddr = 32'h50;
        cyc();
        m0.MCmd = OCP_CMD_IDLE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("to_wait_resp0", m0.SResp, OCP_RESP_NULL);
            cyc();
        end
        @(negedge clk);
        chk("to_err_resp0", m0.SResp, OCP_RESP_ERR);
        chk("to_err_data0", m0.SData, 32'hDEADDEAD);
        cyc();
        s.SResp = OCP_RESP_DVA; s.SData = 32'h11111111;
        s.SCmdAccept = 1'b0; m1.MCmd = OCP_CMD_READ; m1.MAddr = 32'h60;
        @(negedge clk);
        chk("to_late_resp0", m0.SResp, OCP_RESP_NULL);
        chk("to_late_data0", m0.SData, 0);
        chk("to_late_resp1", m1.SResp, OCP_RESP_NULL);
        chk("to_idle_mcmd",  s.MCmd, OCP_CMD_READ);
        chk("to_idle_maddr", s.MAddr, 32'h60);
        cyc();
        m1.MCmd = OCP_CMD_IDLE; s.SResp = OCP_RESP_NULL; s.SData = '0; s.SCmdAccept = 1'b1;
        cyc();

        // Response in the timeout cycle wins over ERR
        m0.MCmd = OCP_CMD_READ; m0.MAddr = 32'h58;
        cyc();
        m0.MCmd = OCP_CMD_IDLE;
        cyc();
        cyc();
        cyc();
        s.SResp = OCP_RESP_DVA; s.SData = 32'hCAFE0001;
        @(negedge clk);
        chk("tw_resp0", m0.SResp, OCP_RESP_DVA);
        chk("tw_data0", m0.SData, 32'hCAFE0001);
        cyc();
        s.SResp = OCP_RESP_NULL; s.SData = '0;

        // Reset in BUSY1, then tie goes to M0
        m1.MCmd = OCP_CMD_READ; m1.MAddr = 32'h70;
        cyc();
        m0.MCmd = OCP_CMD_READ; m0.MAddr = 32'h80; m1.MAddr = 32'h90;
        @(negedge clk);
        #1;
        nrst = 1'b0; s.SResp = OCP_RESP_DVA; s.SData = 32'h5555;
        #1;
        chk("mr_mcmd",  s.MCmd, OCP_CMD_IDLE);
        chk("mr_maddr", s.MAddr, 0);
        chk("mr_mdata", s.MData, 0);
        chk("mr_acc0",  m0.SCmdAccept, 0);
        chk("mr_acc1",  m1.SCmdAccept, 0);
        chk("mr_resp1", m1.SResp, OCP_RESP_NULL);
        chk("mr_data1", m1.SData, 0);
        cyc();
        nrst = 1'b1;
        @(negedge clk);
        chk("mr_post_resp1", m1.SResp, OCP_RESP_NULL);
        chk("mr_post_resp0", m0.SResp, OCP_RESP_NULL);
        chk("mr_tie_maddr",  s.MAddr, 32'h80);
        chk("mr_tie_acc0",   m0.SCmdAccept, 1);
        chk("mr_tie_acc1",   m1.SCmdAccept, 0);
        cyc();
        m0.MCmd = OCP_CMD_IDLE; m1.MCmd = OCP_CMD_IDLE; s.SResp = OCP_RESP_NULL;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
